// File: rtl/roi_pkg.sv
// Shared definitions for the ROI stream FIFO: widths, coordinate field bounds,
// length-check states and the ROI area helper.
package roi_pkg;

    localparam int unsigned BIT_D_DEF = 8;
    localparam int unsigned BIT_C_DEF = 32;

    localparam int unsigned X_MSB = 26;
    localparam int unsigned X_LSB = 16;
    localparam int unsigned Y_MSB = 9;
    localparam int unsigned Y_LSB = 0;

    localparam int unsigned XW    = X_MSB - X_LSB + 1;
    localparam int unsigned YW    = Y_MSB - Y_LSB + 1;
    localparam int unsigned EXP_W = 21;

    typedef enum logic {
        LC_IDLE,
        LC_FRAME
    } lc_state_e;

    // Pixel count of the rectangle spanned by two inclusive corners, modulo 2^EXP_W.
    function automatic logic [EXP_W-1:0] roi_area(
        input logic [XW-1:0] x0,
        input logic [XW-1:0] x1,
        input logic [YW-1:0] y0,
        input logic [YW-1:0] y1
    );
        logic [XW:0] dx;
        logic [YW:0] dy;
        dx = (x1 >= x0) ? {1'b0, x1 - x0} : {1'b0, x0 - x1};
        dy = (y1 >= y0) ? {1'b0, y1 - y0} : {1'b0, y0 - y1};
        dx = dx + (XW+1)'(1);
        dy = dy + (YW+1)'(1);
        return EXP_W'(dx) * EXP_W'(dy);
    endfunction

endpackage

// File: rtl/roi_fifo_mem.sv
// Simple dual-port FIFO storage with one write port and a registered read port.
module roi_fifo_mem
    import roi_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = BIT_D_DEF + 1
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The array itself is never reset; only the read register is, so the
    // downstream output stage comes up clean.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/roi_stream_fifo.sv
// FWFT stream FIFO for cropped ROI pixels with overflow and frame-length checking.
// Define ROI_FIFO_LEN_CHECK_EN to build the length-check state machine.
module roi_stream_fifo
    import roi_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned BIT_D = BIT_D_DEF,
    parameter int unsigned BIT_C = BIT_C_DEF
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic [BIT_D-1:0]         s_tdata_i,
    input  logic                     s_tvalid_i,
    input  logic                     s_tlast_i,
    input  logic [BIT_C-1:0]         xy_0_i,
    input  logic [BIT_C-1:0]         xy_1_i,
    input  logic                     clr_i,
    output logic [BIT_D-1:0]         m_tdata_o,
    output logic                     m_tvalid_o,
    input  logic                     m_tready_i,
    output logic                     m_tlast_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o,
    output logic                     len_err_o,
    output logic [15:0]              frame_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic          full;
    logic          wr_en;
    logic          rd_en;
    logic          xfer;
    logic [LW-1:0] ram_cnt;
    logic [BIT_D:0] rdata;
    logic          unused_xy;

    assign unused_xy = ^{xy_0_i, xy_1_i};

    // Fullness is judged on the registered level, so a pop in the same cycle
    // cannot make room for a write.
    assign full    = (level_q == LW'(DEPTH));
    assign wr_en   = s_tvalid_i && !full;
    assign xfer    = m_tvalid_q && m_tready_i;
    assign ram_cnt = level_q - LW'(m_tvalid_q);
    assign rd_en   = (ram_cnt != '0) && (!m_tvalid_q || m_tready_i);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        m_tvalid_d  = m_tvalid_q;
        frame_cnt_d = frame_cnt_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            m_tvalid_d = 1'b1;
        end else if (xfer) begin
            m_tvalid_d = 1'b0;
        end

        case ({wr_en, xfer})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (xfer && rdata[BIT_D]) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        ovf_d = (ovf_q && !clr_i) || (s_tvalid_i && full);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            m_tvalid_q  <= 1'b0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            m_tvalid_q  <= m_tvalid_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    roi_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (BIT_D + 1)
    ) u_mem (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({s_tlast_i, s_tdata_i}),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign m_tdata_o   = rdata[BIT_D-1:0];
    assign m_tlast_o   = rdata[BIT_D];
    assign m_tvalid_o  = m_tvalid_q;
    assign level_o     = level_q;
    assign ovf_o       = ovf_q;
    assign frame_cnt_o = frame_cnt_q;

`ifdef ROI_FIFO_LEN_CHECK_EN
    lc_state_e        lc_state_q, lc_state_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             drop_q, drop_d;
    logic             len_err_q, len_err_d;
    logic [EXP_W-1:0] area;
    logic [EXP_W-1:0] cnt_inc;

    assign area = roi_area(xy_0_i[X_MSB:X_LSB], xy_1_i[X_MSB:X_LSB],
                           xy_0_i[Y_MSB:Y_LSB], xy_1_i[Y_MSB:Y_LSB]);
    assign cnt_inc = cnt_q + EXP_W'(1);

    always_comb begin
        lc_state_d = lc_state_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        drop_d     = drop_q;
        len_err_d  = 1'b0;

        case (lc_state_q)
            LC_IDLE: begin
                if (wr_en) begin
                    exp_d = area;
                    if (s_tlast_i) begin
                        len_err_d = (area != EXP_W'(1));
                    end else begin
                        lc_state_d = LC_FRAME;
                        cnt_d      = EXP_W'(1);
                        drop_d     = 1'b0;
                    end
                end
            end
            LC_FRAME: begin
                if (wr_en) begin
                    cnt_d = cnt_inc;
                    if (s_tlast_i) begin
                        lc_state_d = LC_IDLE;
                        len_err_d  = (cnt_inc != exp_q) || drop_q;
                        drop_d     = 1'b0;
                    end
                end else if (s_tvalid_i) begin
                    drop_d = 1'b1;
                end
            end
            default: lc_state_d = LC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            lc_state_q <= LC_IDLE;
            cnt_q      <= '0;
            exp_q      <= '0;
            drop_q     <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            lc_state_q <= lc_state_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            drop_q     <= drop_d;
            len_err_q  <= len_err_d;
        end
    end

    assign len_err_o = len_err_q;
`else
    assign len_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_roi_stream_fifo.sv
// Directed and randomized bench for roi_stream_fifo against a queue-based reference model.
module tb_roi_stream_fifo;

    localparam int DEPTH = 4;
    localparam int BD    = 8;
    localparam int BC    = 32;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic [BD-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic [BC-1:0] xy_0 = '0;
    logic [BC-1:0] xy_1 = '0;
    logic          clr = 1'b0;
    logic [BD-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic [$clog2(DEPTH):0] level;
    logic          ovf;
    logic          len_err;
    logic [15:0]   frame_cnt;

    roi_stream_fifo #(
        .DEPTH (DEPTH),
        .BIT_D (BD),
        .BIT_C (BC)
    ) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .s_tdata_i   (s_tdata),
        .s_tvalid_i  (s_tvalid),
        .s_tlast_i   (s_tlast),
        .xy_0_i      (xy_0),
        .xy_1_i      (xy_1),
        .clr_i       (clr),
        .m_tdata_o   (m_tdata),
        .m_tvalid_o  (m_tvalid),
        .m_tready_i  (m_tready),
        .m_tlast_o   (m_tlast),
        .level_o     (level),
        .ovf_o       (ovf),
        .len_err_o   (len_err),
        .frame_cnt_o (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BD-1:0] d;
        logic          l;
        int            w;
    } ent_t;

    ent_t        q[$];
    int          cyc;
    logic        ovf_m;
    logic [15:0] fc_m;
    logic        lerr_m;
    bit          in_frame;
    int          beats;
    int          exp_area;
    bit          dropped;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [BC-1:0] mkxy(input int x, input int y);
        return (BC'(x) << 16) | BC'(y);
    endfunction

    // Expected ROI size from the current corner inputs, wrapped to 21 bits.
    function automatic int area_now();
        int x0, x1, y0, y1, w, h;
        x0 = int'(xy_0[26:16]);
        x1 = int'(xy_1[26:16]);
        y0 = int'(xy_0[9:0]);
        y1 = int'(xy_1[9:0]);
        w = (x1 > x0 ? x1 - x0 : x0 - x1) + 1;
        h = (y1 > y0 ? y1 - y0 : y0 - y1) + 1;
        return (w * h) % (1 << 21);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cyc      = 0;
        ovf_m    = 1'b0;
        fc_m     = '0;
        lerr_m   = 1'b0;
        in_frame = 1'b0;
        beats    = 0;
        exp_area = 0;
        dropped  = 1'b0;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model past the edge.
    task automatic cycle();
        bit   ev;
        bit   full;
        bit   drop_now;
        logic lerr_next;
        @(negedge clk);
        ev = (q.size() > 0) && (cyc >= q[0].w + 2);
        check("valid", 32'(m_tvalid), 32'(ev));
        check("level", 32'(level), 32'(q.size()));
        if (ev) begin
            check("data", 32'(m_tdata), 32'(q[0].d));
            check("last", 32'(m_tlast), 32'(q[0].l));
        end
        check("ovf", 32'(ovf), 32'(ovf_m));
        check("frame_cnt", 32'(frame_cnt), 32'(fc_m));
        check("len_err", 32'(len_err), 32'(lerr_m));

        lerr_next = 1'b0;
        full      = (q.size() == DEPTH);
        drop_now  = s_tvalid && full;
        if (s_tvalid) begin
            if (full) begin
                if (in_frame) dropped = 1'b1;
            end else begin
                q.push_back('{d: s_tdata, l: s_tlast, w: cyc});
`ifdef ROI_FIFO_LEN_CHECK_EN
                if (!in_frame) begin
                    exp_area = area_now();
                    if (s_tlast) lerr_next = (exp_area != 1);
                    else begin
                        in_frame = 1'b1;
                        beats    = 1;
                    end
                end else begin
                    beats++;
                    if (s_tlast) begin
                        lerr_next = (beats != exp_area) || dropped;
                        in_frame  = 1'b0;
                        dropped   = 1'b0;
                    end
                end
`else
                if (!in_frame && !s_tlast) in_frame = 1'b1;
                else if (in_frame && s_tlast) in_frame = 1'b0;
`endif
            end
        end
        ovf_m = (ovf_m && !clr) || drop_now;
        if (ev && m_tready) begin
            if (q[0].l) fc_m = fc_m + 16'd1;
            void'(q.pop_front());
        end
        lerr_m = lerr_next;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic beat(input logic v, input logic [BD-1:0] d, input logic l, input logic r);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = r;
        clr      = 1'b0;
        cycle();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q.size() > 0 || lerr_m); i++) beat(1'b0, '0, 1'b0, 1'b1);
        check("drain_empty", 32'(q.size()), 32'(0));
    endtask

    task automatic do_reset();
        arst = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        clr = 1'b0;
        #2;
        check("rst_valid", 32'(m_tvalid), 32'(0));
        check("rst_data", 32'(m_tdata), 32'(0));
        check("rst_last", 32'(m_tlast), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        check("rst_len_err", 32'(len_err), 32'(0));
        check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1;
        do_reset();

        // Scenario 1/2: 12-beat frame of a 4x3 ROI, consumer always ready.
        xy_0 = mkxy(10, 20);
        xy_1 = mkxy(13, 22);
        for (int i = 1; i <= 12; i++) beat(1'b1, BD'(i), (i == 12), 1'b1);
        drain();
        check("s1_frame_cnt", 32'(frame_cnt), 32'(1));

        // Scenario 5: short frame then a correct one.
        for (int i = 1; i <= 11; i++) beat(1'b1, BD'(8'h40 + i), (i == 11), 1'b1);
        drain();
        for (int i = 1; i <= 12; i++) beat(1'b1, BD'(8'h60 + i), (i == 12), 1'b1);
        drain();

        // Scenario 3: six beats into a stalled 4-deep FIFO, then release.
        for (int i = 1; i <= 6; i++) beat(1'b1, BD'(8'h80 + i), 1'b0, 1'b0);
        check("s3_level", 32'(level), 32'(DEPTH));
        check("s3_ovf", 32'(ovf), 32'(1));
        s_tvalid = 1'b1; s_tdata = 8'hAA; s_tlast = 1'b0; m_tready = 1'b0; clr = 1'b1;
        cycle();
        drain();
        for (int i = 1; i <= 2; i++) beat(1'b1, BD'(8'h90 + i), (i == 2), 1'b1);
        drain();
        s_tvalid = 1'b0; clr = 1'b1;
        cycle();
        check("s3_ovf_clr", 32'(ovf), 32'(0));

        // Scenario 4: 100-beat 10x10 frame against a ready that toggles every cycle.
        xy_0 = mkxy(0, 0);
        xy_1 = mkxy(9, 9);
        begin
            int sent;
            sent = 0;
            for (int c = 0; c < 600 && sent < 100; c++) begin
                if (q.size() < DEPTH) begin
                    beat(1'b1, BD'($urandom), (sent == 99), 1'(cyc % 2));
                    sent++;
                end else begin
                    beat(1'b0, '0, 1'b0, 1'(cyc % 2));
                end
            end
            check("s4_sent", 32'(sent), 32'(100));
        end
        drain();

        // Randomized traffic with coordinate changes mid-frame.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                xy_0 = mkxy(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
                xy_1 = mkxy(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
            end
            s_tvalid = ($urandom_range(0, 9) < 7);
            s_tdata  = BD'($urandom);
            s_tlast  = in_frame && ($urandom_range(0, 7) == 0);
            m_tready = ($urandom_range(0, 2) != 0);
            clr      = ($urandom_range(0, 19) == 0);
            cycle();
        end
        s_tvalid = 1'b0; clr = 1'b0;
        drain();

        // Scenario 6: reset in the middle of a frame with three entries held.
        xy_0 = mkxy(10, 20);
        xy_1 = mkxy(13, 22);
        for (int i = 1; i <= 3; i++) beat(1'b1, BD'(8'hC0 + i), 1'b0, 1'b0);
        check("s6_level", 32'(level), 32'(3));
        do_reset();
        for (int i = 1; i <= 12; i++) beat(1'b1, BD'(8'hD0 + i), (i == 12), 1'b1);
        drain();
        check("s6_frame_cnt", 32'(frame_cnt), 32'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/roi_stream_fifo.md
ROI_STREAM_FIFO -- requirements
Module: roi_stream_fifo

Interface
REQ-001 Parameter DEPTH, default 1024: FIFO entries, power of two, at least 4.
REQ-002 Parameter BIT_D, default 8: pixel width.
REQ-003 Parameter BIT_C, default 32: coordinate register width.
REQ-004 clk_i  input  1  clock; all logic on rising edge.
REQ-005 arst_i  input  1  reset, asynchronous, active-high.
REQ-006 s_tdata_i  input  BIT_D  cropped ROI pixel from the upstream crop stage.
REQ-007 s_tvalid_i  input  1  pixel valid; no backpressure upstream.
REQ-008 s_tlast_i  input  1  last ROI pixel of the frame.
REQ-009 xy_0_i / xy_1_i  input  BIT_C each  ROI corners; x in [26:16], y in [9:0].
REQ-010 clr_i  input  1  synchronous clear of sticky status.
REQ-011 m_tdata_o  output  BIT_D  pixel to the consumer.
REQ-012 m_tvalid_o  output  1  output beat valid.
REQ-013 m_tready_i  input  1  consumer ready.
REQ-014 m_tlast_o  output  1  last beat of the ROI frame.
REQ-015 level_o  output  $clog2(DEPTH)+1  stored entry count, including the output register.
REQ-016 ovf_o  output  1  sticky overflow flag.
REQ-017 len_err_o  output  1  one-cycle frame-length-error pulse.
REQ-018 frame_cnt_o  output  16  count of frames delivered.

Function
REQ-019 Each entry stores {tlast, tdata}; write occurs when s_tvalid_i=1 and level_o<DEPTH.
REQ-020 s_tvalid_i=1 while level_o==DEPTH: beat dropped, ovf_o set to 1, and the beat counter is not advanced.
REQ-021 Simultaneous write and pop at full: write rejected, because fullness is evaluated before the pop.
REQ-022 Output is first-word-fall-through with a registered output stage.
- Write in cycle N into an empty FIFO -> m_tvalid_o=1 in cycle N+2.
REQ-023 Transfer occurs on m_tvalid_o && m_tready_i; back-to-back transfers at one beat per cycle are sustained.
REQ-024 m_tdata_o and m_tlast_o are held stable while m_tvalid_o=1 and m_tready_i=0.
REQ-025 level_o changes as follows:
- +1 on write only;
- -1 on transfer only;
- unchanged on both;
- never exceeds DEPTH and never wraps.
REQ-026 Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-027 frame_cnt_o increments on every transfer with m_tlast_o=1 and wraps from 65535 to 0.
REQ-028 clr_i=1 clears ovf_o; if an overflow occurs in the same cycle, set wins.
REQ-029 Length-check state machine (states IDLE, FRAME); len_err_o is 0 in every cycle other than those defined below.
- IDLE -> FRAME on the first accepted beat without tlast, latching EXP = (|x1-x0|+1)*(|y1-y0|+1), computed at 21-bit width, and setting CNT=1.
- FRAME: CNT+1 on each accepted beat.
- On an accepted tlast beat -> IDLE, with len_err_o=1 for one cycle if CNT+1 != EXP.
- In IDLE, an accepted beat with tlast compares 1 against EXP.
REQ-030 A dropped beat (REQ-020) in FRAME forces len_err_o at that frame's tlast.
REQ-031 Coordinate changes mid-frame do not affect the latched EXP.

Reset
REQ-032 On arst_i, regardless of the operation in progress, the following are cleared:
- pointers, level_o, m_tvalid_o, m_tdata_o, m_tlast_o, ovf_o, len_err_o, frame_cnt_o;
- state machine goes to IDLE, with CNT=0 and EXP=0.
REQ-033 After deassertion, a beat accepted in the first clock behaves per REQ-022.
REQ-034 RAM contents are not reset.

Configuration
REQ-035 Macro ROI_FIFO_LEN_CHECK_EN defined: REQ-029 to REQ-031 are implemented.
REQ-036 Macro ROI_FIFO_LEN_CHECK_EN undefined: no length-check logic is instantiated and len_err_o is tied to 0.

Structure
REQ-037 Shared package roi_pkg holds:
- BIT_D/BIT_C defaults;
- coordinate field bounds X_MSB=26, X_LSB=16, Y_MSB=9, Y_LSB=0;
- the length-check state enum.
REQ-038 Storage is sub-module roi_fifo_mem: simple dual-port RAM, DEPTH x (BIT_D+1), registered read, one write port and one read port.

Verification
REQ-039 Scenario 1: xy_0=(10,20), xy_1=(13,22), 12-beat frame with tlast on beat 12, m_tready_i=1 -> 12 beats in order, tlast on beat 12, len_err_o=0, frame_cnt_o=1.
REQ-040 Scenario 2: same frame, first beat in cycle 0 -> m_tvalid_o first high in cycle 2.
REQ-041 Scenario 3: DEPTH=4, 6 beats with m_tready_i=0 -> level_o=4, ovf_o=1; after ready, exactly 4 beats output, and len_err_o pulses at tlast if tlast arrived.
REQ-042 Scenario 4: m_tready_i toggling every cycle over 100 beats -> data stable while stalled, no loss, no duplication.
REQ-043 Scenario 5: EXP=12, tlast on beat 11 -> len_err_o=1 for one cycle; next 12-beat frame -> len_err_o=0.
REQ-044 Scenario 6: arst_i asserted mid-frame with level_o=3 -> all outputs 0; the next frame is handled correctly, with frame_cnt_o=1 after it.
